// File: rtl/image_buffer_writer.sv
// Double-buffered image loader: fills two pixel banks from a stream and presents full banks to a reader.
// Optional image-length checking on s_last is enabled by defining IMAGE_LEN_CHECK_EN.
module image_buffer_writer #(
    parameter int XLEN_PIXEL    = 8,
    parameter int NUM_OF_PIXELS = 784,
    parameter int ADDR_W        = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [XLEN_PIXEL-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  frame_valid,
    output logic                  frame_bank,
    input  logic                  frame_release,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [XLEN_PIXEL-1:0] x_test,
    output logic                  x_test_valid,
    output logic                  frame_err
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OF_PIXELS - 1);
    localparam logic [ADDR_W:0]   NUM_EXT  = (ADDR_W + 1)'(NUM_OF_PIXELS);

    logic [XLEN_PIXEL-1:0] mem [0:1][0:NUM_OF_PIXELS-1];

    logic [1:0]            full_q, full_d;
    logic                  wbank_q, wbank_d;
    logic                  rbank_q, rbank_d;
    logic [ADDR_W-1:0]     wcnt_q, wcnt_d;
    logic [XLEN_PIXEL-1:0] x_test_q, x_test_d;
    logic                  x_vld_q, x_vld_d;
    logic                  accept;
    logic                  at_last;
    logic                  release_ok;
    logic                  addr_ok;

`ifdef IMAGE_LEN_CHECK_EN
    logic                  err_q, err_d;
    assign frame_err = err_q;
`else
    logic                  unused_s_last;
    assign unused_s_last = s_last;
    assign frame_err     = 1'b0;
`endif

    assign s_ready      = !full_q[wbank_q];
    assign frame_valid  = full_q[rbank_q];
    assign frame_bank   = rbank_q;
    assign x_test       = x_test_q;
    assign x_test_valid = x_vld_q;

    assign accept     = s_valid && s_ready;
    assign at_last    = (wcnt_q == LAST_IDX);
    assign release_ok = frame_release && full_q[rbank_q];
    assign addr_ok    = ({1'b0, rd_addr} < NUM_EXT);

    always_comb begin
        full_d   = full_q;
        wbank_d  = wbank_q;
        rbank_d  = rbank_q;
        wcnt_d   = wcnt_q;
        x_test_d = x_test_q;
        x_vld_d  = 1'b0;
`ifdef IMAGE_LEN_CHECK_EN
        err_d    = 1'b0;
`endif

        if (accept) begin
`ifdef IMAGE_LEN_CHECK_EN
            // Early s_last throws away the partial image; a missing s_last still commits.
            if (s_last && !at_last) begin
                wcnt_d = '0;
                err_d  = 1'b1;
            end else if (at_last) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = !wbank_q;
                wcnt_d          = '0;
                err_d           = !s_last;
            end else begin
                wcnt_d = wcnt_q + ADDR_W'(1);
            end
`else
            if (at_last) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = !wbank_q;
                wcnt_d          = '0;
            end else begin
                wcnt_d = wcnt_q + ADDR_W'(1);
            end
`endif
        end

        // Commit can only target a non-full bank and release only a full one, so they never collide.
        if (release_ok) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = !rbank_q;
        end

        if (rd_en) begin
            if (full_q[rbank_q]) begin
                x_test_d = addr_ok ? mem[rbank_q][rd_addr] : '0;
                x_vld_d  = 1'b1;
            end else begin
                x_test_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q   <= '0;
            wbank_q  <= 1'b0;
            rbank_q  <= 1'b0;
            wcnt_q   <= '0;
            x_test_q <= '0;
            x_vld_q  <= 1'b0;
`ifdef IMAGE_LEN_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            full_q   <= full_d;
            wbank_q  <= wbank_d;
            rbank_q  <= rbank_d;
            wcnt_q   <= wcnt_d;
            x_test_q <= x_test_d;
            x_vld_q  <= x_vld_d;
`ifdef IMAGE_LEN_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    // Pixel storage keeps its contents across reset and release.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wbank_q][wcnt_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_image_buffer_writer.sv
// Directed bench for image_buffer_writer with a frame-queue reference model checked every cycle.
module tb_image_buffer_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic       frame_valid;
    logic       frame_bank;
    logic       frame_release = 1'b0;
    logic       rd_en = 1'b0;
    logic [9:0] rd_addr = 10'd0;
    logic [7:0] x_test;
    logic       x_test_valid;
    logic       frame_err;

    image_buffer_writer #(
        .XLEN_PIXEL(8),
        .NUM_OF_PIXELS(784),
        .ADDR_W(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_last(s_last),
        .s_ready(s_ready),
        .frame_valid(frame_valid),
        .frame_bank(frame_bank),
        .frame_release(frame_release),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .x_test(x_test),
        .x_test_valid(x_test_valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: committed images form a FIFO of bank ids; the pending image is a pixel queue.
    int         frm_q[$];
    logic [7:0] pend[$];
    logic [7:0] mbank [0:1][0:783];
    int         ncommit = 0;
    int         nrel = 0;
    int         m_wb = 0;
    logic [7:0] m_x = 8'h0;
    logic       m_xv = 1'b0;
    logic       m_err = 1'b0;
    bit         m_rel;
    bit         m_commit;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            frm_q.delete();
            pend.delete();
            ncommit = 0;
            nrel    = 0;
            m_x     = 8'h0;
            m_xv    = 1'b0;
            m_err   = 1'b0;
        end else begin
            m_err    = 1'b0;
            m_commit = 1'b0;
            if (rd_en) begin
                if (frm_q.size() > 0) begin
                    m_x  = (rd_addr < 10'd784) ? mbank[frm_q[0]][rd_addr] : 8'h0;
                    m_xv = 1'b1;
                end else begin
                    m_x  = 8'h0;
                    m_xv = 1'b0;
                end
            end else begin
                m_xv = 1'b0;
            end
            m_rel = frame_release && (frm_q.size() > 0);
            if (s_valid && (frm_q.size() < 2)) begin
                pend.push_back(s_data);
`ifdef IMAGE_LEN_CHECK_EN
                if (s_last && pend.size() < 784) begin
                    pend.delete();
                    m_err = 1'b1;
                end else
`endif
                if (pend.size() == 784) begin
                    m_wb = ncommit % 2;
                    foreach (pend[k]) mbank[m_wb][k] = pend[k];
                    pend.delete();
                    ncommit++;
                    m_commit = 1'b1;
`ifdef IMAGE_LEN_CHECK_EN
                    m_err = !s_last;
`endif
                end
            end
            if (m_rel) begin
                void'(frm_q.pop_front());
                nrel++;
            end
            if (m_commit) frm_q.push_back(m_wb);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("cyc_s_ready", s_ready, frm_q.size() < 2);
            chk("cyc_frame_valid", frame_valid, frm_q.size() > 0);
            chk("cyc_frame_bank", frame_bank, nrel % 2);
            chk("cyc_x_test", x_test, m_x);
            chk("cyc_x_test_valid", x_test_valid, m_xv);
            chk("cyc_frame_err", frame_err, m_err);
        end
    end

    function automatic logic [7:0] pix(input int mode, input int i);
        case (mode)
            0:       pix = 8'(i % 256);
            1:       pix = 8'hAA;
            2:       pix = 8'h55;
            3:       pix = 8'h11;
            4:       pix = 8'h22;
            default: pix = 8'((i * 3) % 256);
        endcase
    endfunction

    task automatic send(input int mode, input int n, input int last_idx, input bit rel_on_last);
        for (int i = 0; i < n; i++) begin
            int guard;
            s_valid = 1'b1;
            s_data  = pix(mode, i);
            s_last  = (i == last_idx);
            guard   = 0;
            while (!s_ready && guard < 50) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (!s_ready) begin
                failures++;
                $display("FAIL send_ready_timeout actual=0 required=1 at %0t", $time);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "s_ready never rose");
            end
            frame_release = rel_on_last && (i == n - 1);
            @(posedge clk);
            #1;
            frame_release = 1'b0;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic read_chk(input string nm, input int addr, input int exp_x, input int exp_v);
        rd_en   = 1'b1;
        rd_addr = 10'(addr);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        chk({nm, "_x"}, x_test, exp_x);
        chk({nm, "_v"}, x_test_valid, exp_v);
    endtask

    task automatic pulse_release();
        frame_release = 1'b1;
        @(posedge clk);
        #1;
        frame_release = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_frame_bank", frame_bank, 0);
        chk("rst_x_test", x_test, 0);
        chk("rst_x_test_valid", x_test_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        rst = 1'b1;

        // Single image, index pattern
        send(0, 784, 783, 1'b0);
        chk("img0_frame_valid", frame_valid, 1);
        chk("img0_frame_bank", frame_bank, 0);
        read_chk("rd5", 5, 5, 1);
        read_chk("rd783", 783, 15, 1);
        read_chk("rd800", 800, 0, 1);
        read_chk("rd783b", 783, 15, 1);
        @(posedge clk);
        #1;
        chk("hold_x", x_test, 15);
        chk("hold_v", x_test_valid, 0);
        pulse_release();
        chk("rel_frame_valid", frame_valid, 0);
        read_chk("rd_empty", 5, 0, 0);

        // Two images back to back, both banks full
        do_reset();
        send(1, 784, 783, 1'b0);
        send(2, 784, 783, 1'b0);
        chk("full_s_ready", s_ready, 0);
        chk("full_frame_bank", frame_bank, 0);
        s_valid = 1'b1;
        s_data  = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0;
        read_chk("rdAA", 3, 8'hAA, 1);
        pulse_release();
        chk("after_rel_bank", frame_bank, 1);
        chk("after_rel_ready", s_ready, 1);
        read_chk("rd55", 3, 8'h55, 1);

        // Release coinciding with the last pixel of the second image
        do_reset();
        send(3, 784, 783, 1'b0);
        send(4, 784, 783, 1'b1);
        chk("same_frame_valid", frame_valid, 1);
        chk("same_frame_bank", frame_bank, 1);
        chk("same_s_ready", s_ready, 1);
        read_chk("rd22", 0, 8'h22, 1);
        pulse_release();

        // Reset in the middle of an image
        do_reset();
        send(0, 400, -1, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("midrst_frame_valid", frame_valid, 0);
        chk("midrst_s_ready", s_ready, 1);
        pulse_release();
        send(5, 784, 783, 1'b0);
        chk("midrst_bank", frame_bank, 0);
        chk("midrst_valid", frame_valid, 1);
        read_chk("rd100", 100, 44, 1);
        read_chk("rd783c", 783, 45, 1);
        pulse_release();

`ifdef IMAGE_LEN_CHECK_EN
        // Length checking
        do_reset();
        send(0, 100, 99, 1'b0);
        chk("short_err", frame_err, 1);
        chk("short_valid", frame_valid, 0);
        @(posedge clk);
        #1;
        chk("short_err_pulse", frame_err, 0);
        send(0, 784, 783, 1'b0);
        chk("good_err", frame_err, 0);
        chk("good_valid", frame_valid, 1);
        chk("good_bank", frame_bank, 0);
        send(1, 784, -1, 1'b0);
        chk("nolast_err", frame_err, 1);
        chk("nolast_ready", s_ready, 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
